// File: rtl/apb_regfile_slave_pkg.sv
// apb_pkg: shared FSM state type, response codes and byte-lane merge helper.
package apb_pkg;
    typedef enum logic {IDLE, ACCESS} apb_state_e;
    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;
    function automatic logic [63:0] strb_merge(input logic [63:0] old_w, input logic [63:0] nw, input logic [7:0] strb);
        for (int i = 0; i < 8; i++) strb_merge[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old_w[8*i +: 8];
    endfunction
endpackage

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB signal bundle with master/slave views.
interface apb_regfile_slave_if #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 32
);
    logic                 p_sel;
    logic                 p_enable;
    logic                 p_write;
    logic [A_WIDTH-1:0]   p_addr;
    logic [D_WIDTH-1:0]   wr_data;
    logic [D_WIDTH/8-1:0] p_strb;
    logic [D_WIDTH-1:0]   rd_data;
    logic                 p_ready;
    logic                 p_slverr;
    modport master(output p_sel, p_enable, p_write, p_addr, wr_data, p_strb, input rd_data, p_ready, p_slverr);
    modport slave(input p_sel, p_enable, p_write, p_addr, wr_data, p_strb, output rd_data, p_ready, p_slverr);
endinterface

// File: rtl/apb_regfile_slave_mem.sv
// apb_byte_mem: word storage with per-byte write enables and combinational read.
module apb_byte_mem import apb_pkg::*; #(
    parameter int                   D_WIDTH   = 32,
    parameter int                   DEPTH     = 16,
    parameter logic [D_WIDTH-1:0]   RESET_VAL = '0,
    localparam int                  IW        = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic                 p_clk,
    input  logic                 p_rst,
    input  logic                 we,
    input  logic [IW-1:0]        addr,
    input  logic [D_WIDTH-1:0]   wdata,
    input  logic [D_WIDTH/8-1:0] strb,
    output logic [D_WIDTH-1:0]   rdata
);
    logic [D_WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge p_clk or posedge p_rst)
        if (p_rst) for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        else if (we) mem[addr] <= D_WIDTH'(strb_merge(64'(mem[addr]), 64'(wdata), 8'(strb)));
endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB slave over a byte-strobed register file with
// programmable wait states and out-of-range error response.
module apb_regfile_slave import apb_pkg::*; #(
    parameter int                 A_WIDTH     = 8,
    parameter int                 D_WIDTH     = 32,
    parameter int                 DEPTH       = 16,
    parameter logic [D_WIDTH-1:0] RESET_VAL   = '0,
    parameter int                 WAIT_STATES = 0
) (
    input logic               p_clk,
    input logic               p_rst,
    apb_regfile_slave_if.slave bus
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [A_WIDTH:0] DEPTH_V = (A_WIDTH+1)'(DEPTH);
    apb_state_e         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               ready, ready_n, slverr, slverr_n, we;
    logic [D_WIDTH-1:0] rd_data, rd_data_n, mem_rd;
    logic               addr_err;
    assign addr_err = {1'b0, bus.p_addr} >= DEPTH_V;
    apb_byte_mem #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) u_mem (
        .p_clk(p_clk), .p_rst(p_rst), .we(we), .addr(bus.p_addr[IW-1:0]),
        .wdata(bus.wr_data), .strb(bus.p_strb), .rdata(mem_rd)
    );
    always_ff @(posedge p_clk or posedge p_rst)
        if (p_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b0;
            slverr  <= APB_OKAY;
            rd_data <= RESET_VAL;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready   <= ready_n;
            slverr  <= slverr_n;
            rd_data <= rd_data_n;
        end
    // Response is loaded at the edge that raises p_ready, so it is valid for the whole ready cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ready_n   = ready;
        slverr_n  = slverr;
        rd_data_n = rd_data;
        we        = 1'b0;
        if (state == IDLE) begin
            if (bus.p_sel && !bus.p_enable) begin
                state_n = ACCESS;
                cnt_n   = CW'(WAIT_STATES);
                if (WAIT_STATES == 0) begin
                    ready_n   = 1'b1;
                    slverr_n  = addr_err ? APB_ERR : APB_OKAY;
                    rd_data_n = bus.p_write ? rd_data : addr_err ? '0 : mem_rd;
                end
            end
        end else if (bus.p_sel && bus.p_enable && ready) begin
            we       = bus.p_write && !addr_err;
            state_n  = IDLE;
            ready_n  = 1'b0;
            slverr_n = APB_OKAY;
        end else if (!bus.p_sel || (!bus.p_enable && !ready)) begin
            state_n  = IDLE;
            ready_n  = 1'b0;
            slverr_n = APB_OKAY;
        end else if (bus.p_enable && cnt != '0) begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                ready_n   = 1'b1;
                slverr_n  = addr_err ? APB_ERR : APB_OKAY;
                rd_data_n = bus.p_write ? rd_data : addr_err ? '0 : mem_rd;
            end
        end
    end
    assign bus.p_ready  = ready;
    assign bus.p_slverr = slverr;
    assign bus.rd_data  = rd_data;
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed checks on three slaves with 0, 3 and 2 wait states.
module tb_apb_regfile_slave;
    localparam logic [31:0] RV = 32'hCAFE_F00D;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sel = '0;
    logic        en = 1'b0, wr = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;
    logic [2:0]  rdy, err;
    logic [31:0] rdat [3];
    int          vecs = 0, errs = 0;
    always #5 clk = ~clk;

    apb_regfile_slave_if #(.A_WIDTH(8), .D_WIDTH(32)) if0 ();
    apb_regfile_slave_if #(.A_WIDTH(8), .D_WIDTH(32)) if1 ();
    apb_regfile_slave_if #(.A_WIDTH(8), .D_WIDTH(32)) if2 ();
    apb_regfile_slave #(.A_WIDTH(8), .D_WIDTH(32), .DEPTH(16), .RESET_VAL(RV), .WAIT_STATES(0)) dut0 (.p_clk(clk), .p_rst(rst), .bus(if0));
    apb_regfile_slave #(.A_WIDTH(8), .D_WIDTH(32), .DEPTH(16), .RESET_VAL(RV), .WAIT_STATES(3)) dut1 (.p_clk(clk), .p_rst(rst), .bus(if1));
    apb_regfile_slave #(.A_WIDTH(8), .D_WIDTH(32), .DEPTH(16), .RESET_VAL(RV), .WAIT_STATES(2)) dut2 (.p_clk(clk), .p_rst(rst), .bus(if2));

    assign if0.p_sel = sel[0];
    assign if1.p_sel = sel[1];
    assign if2.p_sel = sel[2];
    assign {if0.p_enable, if1.p_enable, if2.p_enable} = {3{en}};
    assign {if0.p_write, if1.p_write, if2.p_write} = {3{wr}};
    assign {if0.p_addr, if1.p_addr, if2.p_addr} = {3{addr}};
    assign {if0.wr_data, if1.wr_data, if2.wr_data} = {3{wdata}};
    assign {if0.p_strb, if1.p_strb, if2.p_strb} = {3{strb}};
    assign rdy = {if2.p_ready, if1.p_ready, if0.p_ready};
    assign err = {if2.p_slverr, if1.p_slverr, if0.p_slverr};
    assign rdat[0] = if0.rd_data;
    assign rdat[1] = if1.rd_data;
    assign rdat[2] = if2.rd_data;

    // Entered and left at a negedge; a following call starts its setup phase immediately.
    task automatic xfer(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er, output int waits);
        sel = '0; sel[k] = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d; strb = s;
        @(negedge clk);
        en = 1'b1; waits = 0;
        while (rdy[k] !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        rd = rdat[k]; er = err[k];
        @(negedge clk);
        sel = '0; en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vecs++; if (rdy[k] !== 1'b0) begin errs++; $display("FAIL reset_ready[%0d] got %b exp 0", k, rdy[k]); end
            vecs++; if (err[k] !== 1'b0) begin errs++; $display("FAIL reset_slverr[%0d] got %b exp 0", k, err[k]); end
            vecs++; if (rdat[k] !== RV) begin errs++; $display("FAIL reset_rdata[%0d] got %h exp %h", k, rdat[k], RV); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 8'd3, 32'hDEADBEEF, 4'hF, rd, er, w);
        vecs++; if (w !== 0) begin errs++; $display("FAIL wr0_waits got %0d exp 0", w); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL wr0_slverr got %b exp 0", er); end
        xfer(0, 1'b0, 8'd3, 32'h0, 4'h0, rd, er, w);
        vecs++; if (w !== 0) begin errs++; $display("FAIL rd0_waits got %0d exp 0", w); end
        vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL rd0_data got %h exp deadbeef", rd); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL rd0_slverr got %b exp 0", er); end
        vecs++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL rd0_ready_drop got %b exp 0", rdy[0]); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 8'd5, 32'h11223344, 4'hF, rd, er, w);
        xfer(0, 1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, rd, er, w);
        xfer(0, 1'b0, 8'd5, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== 32'h11BB33DD) begin errs++; $display("FAIL strobe_merge got %h exp 11bb33dd", rd); end
        xfer(0, 1'b1, 8'd5, 32'hFFFFFFFF, 4'h0, rd, er, w);
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL strb0_slverr got %b exp 0", er); end
        vecs++; if (w !== 0) begin errs++; $display("FAIL strb0_waits got %0d exp 0", w); end
        xfer(0, 1'b0, 8'd5, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== 32'h11BB33DD) begin errs++; $display("FAIL strb0_data got %h exp 11bb33dd", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int w;
        xfer(1, 1'b0, 8'd0, 32'h0, 4'h0, rd, er, w);
        vecs++; if (w !== 3) begin errs++; $display("FAIL ws3_waits got %0d exp 3", w); end
        vecs++; if (rd !== RV) begin errs++; $display("FAIL ws3_data got %h exp %h", rd, RV); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL ws3_slverr got %b exp 0", er); end
        vecs++; if (rdy[1] !== 1'b0) begin errs++; $display("FAIL ws3_ready_one_cycle got %b exp 0", rdy[1]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int w;
        xfer(1, 1'b1, 8'd9, 32'h0F0F1234, 4'hF, rd, er, w);
        xfer(1, 1'b1, 8'd10, 32'h76543210, 4'hF, rd, er, w);
        vecs++; if (w !== 3) begin errs++; $display("FAIL b2b_waits got %0d exp 3", w); end
        xfer(1, 1'b0, 8'd9, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== 32'h0F0F1234) begin errs++; $display("FAIL b2b_rd9 got %h exp 0f0f1234", rd); end
        xfer(1, 1'b0, 8'd10, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== 32'h76543210) begin errs++; $display("FAIL b2b_rd10 got %h exp 76543210", rd); end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 8'd16, 32'h01020304, 4'hF, rd, er, w);
        vecs++; if (er !== 1'b1) begin errs++; $display("FAIL err_wr_slverr got %b exp 1", er); end
        vecs++; if (w !== 0) begin errs++; $display("FAIL err_wr_waits got %0d exp 0", w); end
        xfer(0, 1'b0, 8'd16, 32'h0, 4'h0, rd, er, w);
        vecs++; if (er !== 1'b1) begin errs++; $display("FAIL err_rd_slverr got %b exp 1", er); end
        vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL err_rd_data got %h exp 0", rd); end
        vecs++; if (err[0] !== 1'b0) begin errs++; $display("FAIL err_clear got %b exp 0", err[0]); end
        xfer(0, 1'b0, 8'd0, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== RV) begin errs++; $display("FAIL err_no_alias got %h exp %h", rd, RV); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL err_ok_slverr got %b exp 0", er); end
    endtask

    task automatic test_no_setup();
        logic [31:0] rd; logic er; int w;
        sel = 3'b001; en = 1'b1; wr = 1'b1; addr = 8'd4; wdata = 32'h99999999; strb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        vecs++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL nosetup_ready got %b exp 0", rdy[0]); end
        sel = '0; en = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 8'd4, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== RV) begin errs++; $display("FAIL nosetup_mem got %h exp %h", rd, RV); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int w;
        sel = 3'b100; en = 1'b0; wr = 1'b1; addr = 8'd7; wdata = 32'h12345678; strb = 4'hF;
        @(negedge clk);
        en = 1'b1;
        vecs++; if (rdy[2] !== 1'b0) begin errs++; $display("FAIL abort_acc1_ready got %b exp 0", rdy[2]); end
        @(negedge clk);
        en = 1'b0;
        vecs++; if (rdy[2] !== 1'b0) begin errs++; $display("FAIL abort_acc2_ready got %b exp 0", rdy[2]); end
        @(negedge clk);
        sel = '0;
        vecs++; if (rdy[2] !== 1'b0) begin errs++; $display("FAIL abort_idle_ready got %b exp 0", rdy[2]); end
        @(negedge clk);
        xfer(2, 1'b0, 8'd7, 32'h0, 4'h0, rd, er, w);
        vecs++; if (w !== 2) begin errs++; $display("FAIL abort_next_waits got %0d exp 2", w); end
        vecs++; if (rd !== RV) begin errs++; $display("FAIL abort_mem got %h exp %h", rd, RV); end
        xfer(2, 1'b1, 8'd7, 32'h55AA55AA, 4'hF, rd, er, w);
        xfer(2, 1'b0, 8'd7, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== 32'h55AA55AA) begin errs++; $display("FAIL abort_recover got %h exp 55aa55aa", rd); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic er; int w;
        sel = 3'b001; en = 1'b0; wr = 1'b1; addr = 8'd2; wdata = 32'h0BADF00D; strb = 4'hF;
        @(negedge clk);
        en = 1'b1;
        vecs++; if (rdy[0] !== 1'b1) begin errs++; $display("FAIL arst_pre_ready got %b exp 1", rdy[0]); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL arst_ready got %b exp 0", rdy[0]); end
        vecs++; if (err[0] !== 1'b0) begin errs++; $display("FAIL arst_slverr got %b exp 0", err[0]); end
        vecs++; if (rdat[0] !== RV) begin errs++; $display("FAIL arst_rdata got %h exp %h", rdat[0], RV); end
        @(negedge clk);
        sel = '0; en = 1'b0; rst = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 8'd2, 32'h0, 4'h0, rd, er, w);
        vecs++; if (rd !== RV) begin errs++; $display("FAIL arst_mem got %h exp %h", rd, RV); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_no_setup();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
